// File: rtl/uart_pkg.sv
// Shared UART types: parity mode, TX/RX FSM states and the baud divider helper.
// Latency: none; this file holds only types and elaboration-time functions.
// Backpressure: none.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    // RX_BREAK holds off after a framing error until the line is back at 1.
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

    localparam int OVERSAMPLE = 16;

    // Clocks per 16x oversample tick, rounded to nearest.
    function automatic int baud_div(input int clock_freq, input int baud);
        return (clock_freq + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous wrap-around FIFO for received UART words.
// Latency: a pushed word is visible on pop_dat the cycle after the push.
// Backpressure: push_rdy drops when full unless a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_vld,
    output logic             push_rdy,
    input  logic [WIDTH-1:0] push_dat,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_fire;
    logic             pop_fire;

    assign full      = (count == (AW+1)'(DEPTH));
    assign pop_vld   = (count != '0);
    // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
    assign push_rdy  = !full || pop_rdy;
    assign push_fire = push_vld && push_rdy;
    assign pop_fire  = pop_vld && pop_rdy;
    // Storage is not reset; gating keeps the output at 0 while empty.
    assign pop_dat   = pop_vld ? mem[rd_ptr] : '0;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + 1'b1;
            if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_fire, pop_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Word storage.
    always_ff @(posedge clk) begin
        if (push_fire) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/uart_core.sv
// UART serialiser/deserialiser with 16x oversampling; RX buffer is a FIFO when UART_RX_FIFO_EN is defined, else one register.
// Latency: TX start bit 1..DIV clocks after accept; rx_valid and error pulses 1 clock after the mid-stop sample.
// Backpressure: tx_ready only in TX idle; a completed RX word meeting a full buffer is dropped with rx_overrun.
module uart_core #(
    parameter int CLOCK_FREQ    = 27000000,
    parameter int BAUD          = 115200,
    parameter int WIDTH         = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    input  logic             rxd,
    output logic             txd,
    output logic             rx_frame_err,
    output logic             rx_parity_err,
    output logic             rx_overrun
);

    import uart_pkg::*;

    localparam int         DIV       = baud_div(CLOCK_FREQ, BAUD);
    localparam int         DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam parity_e    PAR_CFG   = parity_e'(PARITY);
    localparam logic [3:0] LAST_DATA = 4'(WIDTH - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    if (DIV < 1) begin : g_bad_div
        $error("uart_core: CLOCK_FREQ too low for BAUD, divider rounds below 1");
    end
    if (RX_FIFO_DEPTH < 2 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_core: RX_FIFO_DEPTH must be a power of two >= 2");
    end

    // ---------------- baud tick ----------------
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_W'(DIV - 1));

    // Free-running divider producing one tick every DIV clocks.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)     div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    // ---------------- transmitter ----------------
    tx_state_e        tx_state;
    tx_state_e        tx_state_nxt;
    logic [WIDTH-1:0] tx_shift;
    logic             tx_par;
    logic             tx_go;        // set on the first tick after accept: start bit begins
    logic [3:0]       tx_tick_cnt;
    logic [3:0]       tx_bit_cnt;
    logic             tx_bit_end;

    assign tx_bit_end = tick && tx_go && (tx_tick_cnt == 4'd15);
    assign tx_ready   = (tx_state == TX_IDLE);

    // TX state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) tx_state <= TX_IDLE;
        else       tx_state <= tx_state_nxt;
    end

    // TX next state and line level; txd follows state so reset forces it high at once.
    always_comb begin
        tx_state_nxt = tx_state;
        txd          = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (tx_valid) tx_state_nxt = TX_START;
            end
            TX_START: begin
                txd = ~tx_go;
                if (tx_bit_end) tx_state_nxt = TX_DATA;
            end
            TX_DATA: begin
                txd = tx_shift[0];
                if (tx_bit_end && tx_bit_cnt == LAST_DATA)
                    tx_state_nxt = (PAR_CFG == PAR_NONE) ? TX_STOP : TX_PARITY;
            end
            TX_PARITY: begin
                txd = tx_par;
                if (tx_bit_end) tx_state_nxt = TX_STOP;
            end
            TX_STOP: begin
                if (tx_bit_end && tx_bit_cnt == LAST_STOP) tx_state_nxt = TX_IDLE;
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    // TX datapath: latch word on accept, then count ticks and bits while framing.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_shift    <= '0;
            tx_par      <= 1'b0;
            tx_go       <= 1'b0;
            tx_tick_cnt <= '0;
            tx_bit_cnt  <= '0;
        end else if (tx_state == TX_IDLE) begin
            tx_go       <= 1'b0;
            tx_tick_cnt <= '0;
            tx_bit_cnt  <= '0;
            if (tx_valid) begin
                tx_shift <= tx_data;
                tx_par   <= (PAR_CFG == PAR_ODD) ? ~^tx_data : ^tx_data;
            end
        end else if (tick) begin
            if (!tx_go) begin
                tx_go <= 1'b1;
            end else begin
                tx_tick_cnt <= tx_tick_cnt + 4'd1;
                if (tx_bit_end) begin
                    if (tx_state == TX_DATA) tx_shift <= tx_shift >> 1;
                    tx_bit_cnt <= (tx_state_nxt != tx_state) ? 4'd0 : tx_bit_cnt + 4'd1;
                end
            end
        end
    end

    // ---------------- receiver ----------------
    logic             rxd_meta;
    logic             rxd_s;
    rx_state_e        rx_state;
    rx_state_e        rx_state_nxt;
    logic [3:0]       rx_tick_cnt;
    logic [3:0]       rx_bit_cnt;
    logic [WIDTH-1:0] rx_shift;
    logic             rx_par_bad;
    logic             rx_sample;
    logic             rx_stop_sample;
    logic             rx_push_vld;
    logic             buf_rdy;
    logic             buf_full;

    // Mid-bit strobe: tick 8 of the start bit, then every 16th tick.
    assign rx_sample      = tick && ((rx_state == RX_START) ? (rx_tick_cnt == 4'd7)
                                                            : (rx_tick_cnt == 4'd15));
    assign rx_stop_sample = rx_sample && (rx_state == RX_STOP);
    assign rx_push_vld    = rx_stop_sample && rxd_s && !rx_par_bad;

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
        end
    end

    // RX state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rx_state <= RX_IDLE;
        else       rx_state <= rx_state_nxt;
    end

    // RX next state; a low start sample or stop sample decides glitch / frame error.
    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            RX_IDLE: begin
                if (!rxd_s) rx_state_nxt = RX_START;
            end
            RX_START: begin
                if (rx_sample) rx_state_nxt = rxd_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (rx_sample && rx_bit_cnt == LAST_DATA)
                    rx_state_nxt = (PAR_CFG == PAR_NONE) ? RX_STOP : RX_PARITY;
            end
            RX_PARITY: begin
                if (rx_sample) rx_state_nxt = RX_STOP;
            end
            RX_STOP: begin
                if (rx_sample) rx_state_nxt = rxd_s ? RX_IDLE : RX_BREAK;
            end
            RX_BREAK: begin
                if (rxd_s) rx_state_nxt = RX_IDLE;
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    // RX datapath: tick/bit counters, LSB-first shift and parity check.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_tick_cnt <= '0;
            rx_bit_cnt  <= '0;
            rx_shift    <= '0;
            rx_par_bad  <= 1'b0;
        end else if (rx_state == RX_IDLE) begin
            rx_tick_cnt <= '0;
            rx_bit_cnt  <= '0;
            rx_par_bad  <= 1'b0;
        end else if (tick) begin
            rx_tick_cnt <= (rx_state == RX_START && rx_sample) ? 4'd0 : rx_tick_cnt + 4'd1;
            if (rx_sample && rx_state == RX_DATA) begin
                rx_shift   <= {rxd_s, rx_shift[WIDTH-1:1]};
                rx_bit_cnt <= rx_bit_cnt + 4'd1;
            end
            if (rx_sample && rx_state == RX_PARITY)
                rx_par_bad <= rxd_s != ((PAR_CFG == PAR_ODD) ? ~^rx_shift : ^rx_shift);
        end
    end

`ifdef UART_RX_FIFO_EN
    uart_rx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push_vld (rx_push_vld),
        .push_rdy (buf_rdy),
        .push_dat (rx_shift),
        .pop_vld  (rx_valid),
        .pop_rdy  (rx_ready),
        .pop_dat  (rx_data),
        .full     (buf_full)
    );
`else
    logic [WIDTH-1:0] hold_dat;
    logic             hold_vld;

    assign buf_full = hold_vld;
    assign buf_rdy  = !hold_vld || rx_ready;
    assign rx_valid = hold_vld;
    assign rx_data  = hold_dat;

    // Single holding register; data stays put until the consumer takes it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_dat <= '0;
            hold_vld <= 1'b0;
        end else if (rx_push_vld && buf_rdy) begin
            hold_dat <= rx_shift;
            hold_vld <= 1'b1;
        end else if (rx_ready) begin
            hold_vld <= 1'b0;
        end
    end
`endif

    // Error pulses, aligned with the cycle a good word would appear on rx_valid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_frame_err  <= rx_stop_sample && !rxd_s;
            rx_parity_err <= rx_stop_sample && rx_par_bad;
            rx_overrun    <= rx_push_vld && buf_full && !buf_rdy;
        end
    end

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: an 8N1 instance for TX and reset, an 8E1 instance for RX.
// RX words are queued as expected when a frame is driven and popped on each rx handshake.
module tb_uart_core;
    import uart_pkg::*;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] tx_data_n, tx_data_e;
    logic       tx_valid_n, tx_valid_e;
    logic       tx_ready_n, tx_ready_e;
    logic [7:0] rx_data_n, rx_data_e;
    logic       rx_valid_n, rx_valid_e;
    logic       rx_ready_n, rx_ready_e;
    logic       rxd_n, rxd_e;
    logic       txd_n, txd_e;
    logic       ferr_n, perr_n, ovr_n;
    logic       ferr_e, perr_e, ovr_e;

    int         n_cmp = 0;
    int         n_mis = 0;
    int         n_ferr = 0;
    int         n_perr = 0;
    int         n_ovr = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_core #(.CLOCK_FREQ(6400000), .BAUD(100000), .WIDTH(8), .PARITY(0),
                .STOP_BITS(1), .RX_FIFO_DEPTH(4)) dut_n (
        .clk(clk), .rstn(rstn), .tx_data(tx_data_n), .tx_valid(tx_valid_n),
        .tx_ready(tx_ready_n), .rx_data(rx_data_n), .rx_valid(rx_valid_n),
        .rx_ready(rx_ready_n), .rxd(rxd_n), .txd(txd_n), .rx_frame_err(ferr_n),
        .rx_parity_err(perr_n), .rx_overrun(ovr_n));

    uart_core #(.CLOCK_FREQ(6400000), .BAUD(100000), .WIDTH(8), .PARITY(2),
                .STOP_BITS(1), .RX_FIFO_DEPTH(4)) dut_e (
        .clk(clk), .rstn(rstn), .tx_data(tx_data_e), .tx_valid(tx_valid_e),
        .tx_ready(tx_ready_e), .rx_data(rx_data_e), .rx_valid(rx_valid_e),
        .rx_ready(rx_ready_e), .rxd(rxd_e), .txd(txd_e), .rx_frame_err(ferr_e),
        .rx_parity_err(perr_e), .rx_overrun(ovr_e));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: score every rx handshake and count error pulses.
    always @(negedge clk) begin
        if (rstn) begin
            if (rx_valid_e && rx_ready_e) begin
                if (exp_q.size() == 0) chk("rx_spurious_valid", 32'(rx_valid_e), 32'd0);
                else                   chk("rx_data", 32'(rx_data_e), 32'(exp_q.pop_front()));
            end
            if (ferr_e) n_ferr++;
            if (perr_e) n_perr++;
            if (ovr_e)  n_ovr++;
        end
    end

    // Drive one 8E1 frame on rxd_e, then one idle bit time.
    task automatic rx_frame(input logic [7:0] d, input logic par_flip, input logic stop_v);
        logic [10:0] bits;
        bits = {stop_v, (^d) ^ par_flip, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rxd_e = bits[i];
            step(64);
        end
        rxd_e = 1'b1;
        step(64);
    endtask

    // Send a byte on the 8N1 instance and check latency, every bit and busy time.
    task automatic tx_send_check(input logic [7:0] d);
        logic [9:0] bits;
        int         n;
        int         cnt;
        int         ready_at;
        bit         seen;
        bits       = {1'b1, d, 1'b0};
        tx_data_n  = d;
        tx_valid_n = 1'b1;
        step(1);
        tx_valid_n = 1'b0;
        chk("tx_ready_after_accept", 32'(tx_ready_n), 32'd0);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 16) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (txd_n == 1'b0) seen = 1'b1;
        end
        chk("tx_start_latency_in_1_to_div", 32'((seen && n >= 1 && n <= DIV) ? n : 0), 32'(n));
        cnt      = 0;
        ready_at = -1;
        while (cnt < 800 && ready_at < 0) begin
            if (cnt >= 32 && ((cnt - 32) % 64) == 0 && ((cnt - 32) / 64) < 10)
                chk($sformatf("tx_bit%0d", (cnt - 32) / 64), 32'(txd_n), 32'(bits[(cnt - 32) / 64]));
            if (tx_ready_n) ready_at = cnt;
            else begin
                @(negedge clk);
                cnt++;
            end
        end
        chk("tx_busy_clocks", 32'(ready_at), 32'd640);
        step(1);
    endtask

    initial begin
        rstn       = 1'b0;
        tx_data_n  = '0;  tx_valid_n = 1'b0;
        tx_data_e  = '0;  tx_valid_e = 1'b0;
        rx_ready_n = 1'b1; rx_ready_e = 1'b1;
        rxd_n      = 1'b1; rxd_e      = 1'b1;

        // Reset values.
        step(3);
        @(negedge clk);
        chk("rst_txd",       32'(txd_n),      32'd1);
        chk("rst_tx_ready",  32'(tx_ready_n), 32'd1);
        chk("rst_rx_valid",  32'(rx_valid_e), 32'd0);
        chk("rst_rx_data",   32'(rx_data_e),  32'd0);
        chk("rst_err_pulses", 32'({ferr_e, perr_e, ovr_e}), 32'd0);
        chk("rst_rx_state",  32'(dut_e.rx_state), 32'(RX_IDLE));
        rstn = 1'b1;
        step(5);

        // TX 8N1: 0xA5.
        tx_send_check(8'hA5);

        // RX even parity: 0x3C.
        exp_q.push_back(8'h3C);
        rx_frame(8'h3C, 1'b0, 1'b1);
        chk("rx_3c_drained", 32'(exp_q.size()), 32'd0);
        chk("rx_3c_no_errors", 32'(n_ferr + n_perr + n_ovr), 32'd0);

        // Glitch rejection: 20-clock low pulse.
        rxd_e = 1'b0;
        step(20);
        rxd_e = 1'b1;
        step(200);
        chk("glitch_no_valid", 32'(rx_valid_e), 32'd0);
        chk("glitch_rx_idle", 32'(dut_e.rx_state), 32'(RX_IDLE));

        // Framing error on 0x55, then good 0x12.
        rx_frame(8'h55, 1'b0, 1'b0);
        chk("ferr_count", 32'(n_ferr), 32'd1);
        chk("ferr_no_valid", 32'(rx_valid_e), 32'd0);
        exp_q.push_back(8'h12);
        rx_frame(8'h12, 1'b0, 1'b1);
        chk("after_ferr_drained", 32'(exp_q.size()), 32'd0);
        chk("ferr_count_stable", 32'(n_ferr), 32'd1);

        // Parity error on 0x66.
        rx_frame(8'h66, 1'b1, 1'b1);
        chk("perr_count", 32'(n_perr), 32'd1);
        chk("perr_no_valid", 32'(rx_valid_e), 32'd0);
        chk("perr_no_ferr", 32'(n_ferr), 32'd1);

        // Overrun: consumer stalled, five bytes sent.
        rx_ready_e = 1'b0;
`ifdef UART_RX_FIFO_EN
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
`else
        exp_q.push_back(8'd1);
`endif
        for (int i = 1; i <= 5; i++) rx_frame(8'(i), 1'b0, 1'b1);
        chk("ovr_valid_held", 32'(rx_valid_e), 32'd1);
        chk("ovr_head_word", 32'(rx_data_e), 32'd1);
`ifdef UART_RX_FIFO_EN
        chk("ovr_count", 32'(n_ovr), 32'd1);
`else
        chk("ovr_count", 32'(n_ovr), 32'd4);
`endif
        rx_ready_e = 1'b1;
        step(20);
        chk("ovr_drained", 32'(exp_q.size()), 32'd0);
        chk("ovr_empty_after", 32'(rx_valid_e), 32'd0);

        // Reset mid-frame: buffered RX word and in-flight TX are both dropped.
        rx_ready_e = 1'b0;
        rx_frame(8'h77, 1'b0, 1'b1);
        chk("pre_rst_rx_held", 32'(rx_valid_e), 32'd1);
        tx_data_n  = 8'hFF;
        tx_valid_n = 1'b1;
        step(1);
        tx_valid_n = 1'b0;
        step(150);
        chk("pre_rst_tx_in_data", 32'(dut_n.tx_state), 32'(TX_DATA));
        rstn = 1'b0;
        #1;
        chk("midrst_txd", 32'(txd_n), 32'd1);
        chk("midrst_tx_ready", 32'(tx_ready_n), 32'd1);
        chk("midrst_rx_valid", 32'(rx_valid_e), 32'd0);
        step(3);
        rstn = 1'b1;
        step(2);
        rx_ready_e = 1'b1;
        tx_send_check(8'h0F);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
